// File: rtl/seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detect_ctrl
//  Brief    : Run controller for a programmable serial bit-pattern detector.
//             Holds the pattern config, arms/disarms matching, counts matches,
//             and ends a run on target count or inactivity timeout.
//  Revision : 1.0  initial release
// ============================================================================
module seq_detect_ctrl #(
    parameter  int PAT_W = 8,
    parameter  int CNT_W = 8,
    parameter  int TO_W  = 16,
    localparam int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             cfg_we_i,
    input  logic [PAT_W-1:0] cfg_pattern_i,
    input  logic [LEN_W-1:0] cfg_len_i,
    input  logic             cfg_overlap_i,
    input  logic [CNT_W-1:0] cfg_target_i,
    input  logic [TO_W-1:0]  cfg_timeout_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             in_valid_i,
    input  logic             in_i,
    output logic             busy_o,
    output logic             detected_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic             cfg_err_o,
    output logic [CNT_W-1:0] match_cnt_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [PAT_W-1:0]   r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    logic [CNT_W-1:0]   r_target;
    logic [TO_W-1:0]    r_timeout;
    // Only PAT_W-1 old bits are kept; the incoming bit completes the window.
    logic [PAT_W-2:0]   r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [TO_W-1:0]    r_to_cnt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_detected;
    logic               r_done;
    logic               r_timeout_p;
    logic               r_cfg_err;

    logic [PAT_W-1:0]   w_hist_nxt;
    logic [PAT_W-1:0]   w_mask;
    logic [LEN_W:0]     w_fill_p1;
    logic [LEN_W-1:0]   w_fill_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [TO_W-1:0]    w_to_nxt;
    logic               w_hit;
    logic               w_done;
    logic               w_tmo;
    logic               w_len_bad;

    always_comb begin
        w_hist_nxt = {r_hist, in_i};
        w_mask     = '0;
        for (int i = 0; i < PAT_W; i++) begin
            w_mask[i] = (LEN_W'(i) < r_len);
        end
        w_fill_p1  = {1'b0, r_fill} + (LEN_W+1)'(1);
        w_fill_nxt = (w_fill_p1 > (LEN_W+1)'(PAT_W)) ? LEN_W'(PAT_W)
                                                     : w_fill_p1[LEN_W-1:0];
        w_hit      = in_valid_i
                  && (w_fill_p1 >= {1'b0, r_len})
                  && (((w_hist_nxt ^ r_pattern) & w_mask) == '0);
        w_cnt_nxt  = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
        w_to_nxt   = r_to_cnt + TO_W'(1);
        w_done     = (r_target != '0) && (w_cnt_nxt == r_target);
        w_tmo      = (r_timeout != '0) && (w_to_nxt == r_timeout);
        w_len_bad  = (r_len == '0) || (r_len > LEN_W'(PAT_W));
    end

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            r_state     <= ST_IDLE;
            r_pattern   <= '0;
            r_len       <= '0;
            r_overlap   <= 1'b0;
            r_target    <= '0;
            r_timeout   <= '0;
            r_hist      <= '0;
            r_fill      <= '0;
            r_to_cnt    <= '0;
            r_cnt       <= '0;
            r_detected  <= 1'b0;
            r_done      <= 1'b0;
            r_timeout_p <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_detected  <= 1'b0;
            r_done      <= 1'b0;
            r_timeout_p <= 1'b0;
            r_cfg_err   <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (cfg_we_i) begin
                    r_pattern <= cfg_pattern_i;
                    r_len     <= cfg_len_i;
                    r_overlap <= cfg_overlap_i;
                    r_target  <= cfg_target_i;
                    r_timeout <= cfg_timeout_i;
                end
                // Start is judged against the config already held, not the one being written.
                if (start_i) begin
                    if (w_len_bad) begin
                        r_cfg_err <= 1'b1;
                    end else begin
                        r_state  <= ST_RUN;
                        r_cnt    <= '0;
                        r_hist   <= '0;
                        r_fill   <= '0;
                        r_to_cnt <= '0;
                    end
                end
            end else begin
                if (cfg_we_i) begin
                    r_cfg_err <= 1'b1;
                end
                if (abort_i) begin
                    r_state <= ST_IDLE;
                end else if (in_valid_i) begin
                    r_hist <= w_hist_nxt[PAT_W-2:0];
                    if (w_hit) begin
                        r_detected <= 1'b1;
                        r_cnt      <= w_cnt_nxt;
                        r_to_cnt   <= '0;
                        r_fill     <= r_overlap ? w_fill_nxt : '0;
                        if (w_done) begin
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_fill   <= w_fill_nxt;
                        r_to_cnt <= w_to_nxt;
                        if (w_tmo) begin
                            r_timeout_p <= 1'b1;
                            r_state     <= ST_IDLE;
                        end
                    end
                end
            end
        end
    end

    assign busy_o      = (r_state == ST_RUN);
    assign detected_o  = r_detected;
    assign done_o      = r_done;
    assign timeout_o   = r_timeout_p;
    assign cfg_err_o   = r_cfg_err;
    assign match_cnt_o = r_cnt;

endmodule
`default_nettype wire
